// File: rtl/mod14_counter_sequencer.sv
// Command sequencer and round-robin arbiter for a mod-14 up/down counter.
// Commands from two requesters are serialised into rest/load/mode/data_in pulses and reported on done.
module mod14_counter_sequencer #(
    parameter int MOD_MAX = 13,
    parameter int STEP_W  = 4
) (
    input  logic              clock,
    input  logic              rest,
    input  logic              req_a_valid,
    output logic              req_a_ready,
    input  logic [1:0]        req_a_op,
    input  logic [STEP_W-1:0] req_a_arg,
    input  logic              req_b_valid,
    output logic              req_b_ready,
    input  logic [1:0]        req_b_op,
    input  logic [STEP_W-1:0] req_b_arg,
    output logic              ctr_rest,
    output logic              ctr_load,
    output logic              ctr_mode,
    output logic [3:0]        ctr_data_in,
    input  logic [3:0]        ctr_data_out,
    output logic              busy,
    output logic              done,
    output logic              done_id,
    output logic [3:0]        done_value,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_UP    = 2'b10;

    localparam logic [STEP_W-1:0] LOAD_MAX = STEP_W'(MOD_MAX);
    localparam logic [STEP_W-1:0] ONE_STEP = STEP_W'(1);

    state_t            state;
    state_t            state_next;
    logic              ptr_b;
    logic [1:0]        op_q;
    logic [STEP_W-1:0] arg_q;
    logic [STEP_W-1:0] remain_q;
    logic              id_q;
    logic              err_q;

    logic              grant_a;
    logic              grant_b;
    logic              accept;
    logic [1:0]        sel_op;
    logic [STEP_W-1:0] sel_arg;
    logic              sel_bad;
    logic              sel_zero;

    // Valid/ready: ready is asserted only in IDLE for the granted, valid requester;
    // a command transfers on a rising edge where valid & ready, and the requester
    // keeps op/arg stable until then. ready never feeds back into valid.
    assign grant_a     = req_a_valid & (~req_b_valid | ~ptr_b);
    assign grant_b     = req_b_valid & (~req_a_valid | ptr_b);
    assign accept      = (state == ST_IDLE) & (grant_a | grant_b);
    assign req_a_ready = (state == ST_IDLE) & grant_a;
    assign req_b_ready = (state == ST_IDLE) & grant_b;

    assign sel_op   = grant_a ? req_a_op  : req_b_op;
    assign sel_arg  = grant_a ? req_a_arg : req_b_arg;
    assign sel_bad  = (sel_op == OP_LOAD) && (sel_arg > LOAD_MAX);
    assign sel_zero = sel_op[1] && (sel_arg == '0);

    always_ff @(posedge clock or negedge rest) begin
        if (!rest) begin
            state    <= ST_IDLE;
            ptr_b    <= 1'b0;
            op_q     <= OP_CLEAR;
            arg_q    <= '0;
            remain_q <= '0;
            id_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                ptr_b    <= grant_a;
                op_q     <= sel_op;
                arg_q    <= sel_arg;
                remain_q <= sel_arg;
                id_q     <= ~grant_a;
                err_q    <= sel_bad;
            end else if (state == ST_EXEC) begin
                remain_q <= remain_q - ONE_STEP;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (sel_bad || sel_zero) ? ST_DONE : ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Count commands stay here until the last step; clear/load take one cycle.
                if (!op_q[1] || remain_q == ONE_STEP) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The counter steps on every non-load cycle, so outside EXEC it is held by reloading itself.
    always_comb begin
        ctr_rest    = ~rest;
        ctr_load    = 1'b1;
        ctr_mode    = 1'b0;
        ctr_data_in = ctr_data_out;
        if (state == ST_EXEC) begin
            case (op_q)
                OP_CLEAR: ctr_rest = 1'b1;
                OP_LOAD:  ctr_data_in = 4'(arg_q);
                default: begin
                    ctr_load = 1'b0;
                    ctr_mode = (op_q == OP_UP);
                end
            endcase
        end
    end

    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign done_id    = done & id_q;
    assign err        = done & err_q;
    assign done_value = done ? ctr_data_out : 4'd0;

endmodule
